// File: rtl/smem_entry_sched.sv
// Round-robin entry scheduler and run supervisor for the SMEM attestation routine.
// Optional macro SMEM_RUN_TIMEOUT_EN adds a per-run cycle limit inside SMEM.
module smem_entry_sched #(
    parameter int          NREQ          = 2,
    parameter logic [15:0] SMEM_BASE     = 16'hA000,
    parameter logic [15:0] SMEM_SIZE     = 16'h4000,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter int          ENTRY_WAIT    = 256,
    parameter logic [15:0] RUN_TIMEOUT   = 16'd4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     pc,
    input  logic            irq,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [NREQ-1:0] done,
    output logic            entry_req,
    output logic            irq_mask,
    output logic            busy,
    output logic            violation
);
    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] LAST      = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam logic [15:0] ENTRY_LIM = 16'(ENTRY_WAIT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ENTRY, IN_RC, FAULT} state_t;

    state_t          state, state_nx;
    logic [NREQ-1:0] win, win_nx, done_q, done_nx;
    logic [PW-1:0]   rr_ptr, rr_nx;
    logic [15:0]     cnt, cnt_nx;
    logic            prev_last;
    logic            in_smem, at_base;
    logic            arb_hit;
    logic [NREQ-1:0] arb_oh;
    logic [PW-1:0]   arb_idx;

    assign in_smem = (pc >= SMEM_BASE) && (pc <= LAST);
    assign at_base = (pc == SMEM_BASE);

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        arb_hit = 1'b0;
        arb_oh  = '0;
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!arb_hit && req[idx]) begin
                arb_hit     = 1'b1;
                arb_oh[idx] = 1'b1;
                arb_idx     = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            win       <= '0;
            done_q    <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            prev_last <= 1'b0;
        end else begin
            state     <= state_nx;
            win       <= win_nx;
            done_q    <= done_nx;
            rr_ptr    <= rr_nx;
            cnt       <= cnt_nx;
            prev_last <= (pc == LAST);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (arb_hit) state_nx = WAIT_ENTRY;
            WAIT_ENTRY: begin
                if (at_base)               state_nx = IN_RC;
                else if (in_smem)          state_nx = FAULT;
                else if (cnt == ENTRY_LIM) state_nx = FAULT;
            end
            IN_RC: begin
                if (irq)                         state_nx = FAULT;
                else if (!in_smem && prev_last)  state_nx = IDLE;
                else if (!in_smem)               state_nx = FAULT;
`ifdef SMEM_RUN_TIMEOUT_EN
                else if (cnt == RUN_TIMEOUT - 16'd1) state_nx = FAULT;
`endif
            end
            FAULT:      if (pc == RESET_HANDLER) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        win_nx  = win;
        done_nx = '0;
        rr_nx   = rr_ptr;
        cnt_nx  = cnt;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    win_nx = arb_oh;
                    rr_nx  = PW'((int'(arb_idx) + 1) % NREQ);
                    cnt_nx = '0;
                end
            end
            WAIT_ENTRY: cnt_nx = at_base ? 16'd0 : cnt + 16'd1;
            IN_RC: begin
                if (state_nx == IDLE) done_nx = win;
`ifdef SMEM_RUN_TIMEOUT_EN
                cnt_nx = cnt + 16'd1;
`else
                if (cnt != 16'hFFFF) cnt_nx = cnt + 16'd1;
`endif
            end
            FAULT:   if (pc == RESET_HANDLER) rr_nx = '0;
            default: ;
        endcase
    end

`ifndef SMEM_RUN_TIMEOUT_EN
    logic unused_run_timeout;
    assign unused_run_timeout = ^RUN_TIMEOUT;
`endif

    // Outputs decode only flops, so they change one edge after the sampled condition.
    assign grant     = (state == WAIT_ENTRY || state == IN_RC) ? win : '0;
    assign done      = done_q;
    assign entry_req = (state == WAIT_ENTRY);
    assign irq_mask  = (state == WAIT_ENTRY || state == IN_RC);
    assign busy      = (state != IDLE);
    assign violation = (state == FAULT);
endmodule

// File: tb/tb_smem_entry_sched.sv
// Directed scoreboard bench for smem_entry_sched (NREQ=2, RUN_TIMEOUT=16).
module tb_smem_entry_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        irq;
    logic [1:0]  req;
    logic [1:0]  grant, done;
    logic        entry_req, irq_mask, busy, violation;

    smem_entry_sched #(.NREQ(2), .RUN_TIMEOUT(16'd16)) dut (
        .clk(clk), .reset(reset), .pc(pc), .irq(irq), .req(req),
        .grant(grant), .done(done), .entry_req(entry_req),
        .irq_mask(irq_mask), .busy(busy), .violation(violation)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Packed view: {grant, done, entry_req, irq_mask, busy, violation}
    localparam logic [7:0] O_IDLE  = 8'b00_00_0000;
    localparam logic [7:0] O_FAULT = 8'b00_00_0011;
    function automatic logic [7:0] o_we(input logic [1:0] g);
        return {g, 2'b00, 4'b1110};
    endfunction
    function automatic logic [7:0] o_in(input logic [1:0] g);
        return {g, 2'b00, 4'b0110};
    endfunction
    function automatic logic [7:0] o_done(input logic [1:0] g);
        return {2'b00, g, 4'b0000};
    endfunction

    task automatic step(input logic [15:0] p, input logic i, input logic [1:0] r,
                        input logic [7:0] e, input string tag);
        exp_t x;
        logic [7:0] obs;
        pc = p; irq = i; req = r;
        x.val = e; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x   = sb.pop_front();
        obs = {grant, done, entry_req, irq_mask, busy, violation};
        vectors++;
        assert (obs === x.val) else begin
            miscompares++;
            $error("FAIL %s: got %b want %b", x.tag, obs, x.val);
        end
    endtask

    initial begin
        reset = 1'b1; pc = 16'h0; irq = 1'b0; req = 2'b00;
        step(16'h0000, 0, 2'b11, O_IDLE, "reset_state");
        step(16'h0000, 0, 2'b11, O_IDLE, "reset_hold");
        reset = 1'b0;

        // Clean run; req dropped mid-run is ignored.
        step(16'h0000, 0, 2'b01, o_we(2'b01),   "grant0");
        step(16'hA000, 0, 2'b00, o_in(2'b01),   "enter");
        step(16'hA002, 0, 2'b00, o_in(2'b01),   "run");
        step(16'hDFFE, 0, 2'b00, o_in(2'b01),   "last");
        step(16'h0000, 0, 2'b00, o_done(2'b01), "done0");
        step(16'h0000, 0, 2'b00, O_IDLE,        "done_pulse_end");

        // Round robin from a fresh reset.
        reset = 1'b1;
        step(16'h0000, 0, 2'b11, O_IDLE, "reset_rr");
        reset = 1'b0;
        step(16'h0000, 0, 2'b11, o_we(2'b01),   "rr_first");
        step(16'hA000, 0, 2'b11, o_in(2'b01),   "rr_enter0");
        step(16'hDFFE, 0, 2'b11, o_in(2'b01),   "rr_last0");
        step(16'h0000, 0, 2'b11, o_done(2'b01), "rr_done0");
        step(16'h0000, 0, 2'b11, o_we(2'b10),   "rr_second");
        step(16'hA000, 0, 2'b10, o_in(2'b10),   "rr_enter1");
        step(16'hDFFE, 0, 2'b10, o_in(2'b10),   "rr_last1");
        step(16'h0000, 0, 2'b10, o_done(2'b10), "rr_done1");
        step(16'h0000, 0, 2'b00, O_IDLE,        "rr_idle");

        // Exit from a non-last address faults; held until reset handler.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "bad_exit_grant");
        step(16'hA000, 0, 2'b01, o_in(2'b01), "bad_exit_enter");
        step(16'hA100, 0, 2'b01, o_in(2'b01), "bad_exit_run");
        step(16'h4400, 0, 2'b01, O_FAULT,     "bad_exit_fault");
        step(16'h4400, 0, 2'b01, O_FAULT,     "fault_hold");
        step(16'h1234, 0, 2'b01, O_FAULT,     "fault_hold2");
        step(16'hFFFE, 0, 2'b11, O_IDLE,      "fault_clear");
        step(16'h0000, 0, 2'b11, o_we(2'b01), "rr_after_fault");

        // irq inside SMEM.
        step(16'hA000, 0, 2'b11, o_in(2'b01), "irq_enter");
        step(16'hA010, 1, 2'b11, O_FAULT,     "irq_fault");
        step(16'hFFFE, 0, 2'b00, O_IDLE,      "irq_clear");

        // Jump into SMEM body instead of entry point.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "mid_entry_grant");
        step(16'hA002, 0, 2'b01, O_FAULT,     "mid_entry_fault");
        step(16'hFFFE, 0, 2'b00, O_IDLE,      "mid_entry_clear");

        // Clean exit coinciding with irq: irq wins.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "exit_irq_grant");
        step(16'hA000, 0, 2'b01, o_in(2'b01), "exit_irq_enter");
        step(16'hDFFE, 0, 2'b01, o_in(2'b01), "exit_irq_last");
        step(16'h0000, 1, 2'b01, O_FAULT,     "exit_irq_fault");
        step(16'hFFFE, 0, 2'b00, O_IDLE,      "exit_irq_clear");

        // Reset mid-run.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "midreset_grant");
        reset = 1'b1;
        step(16'hA000, 0, 2'b01, O_IDLE, "midreset");
        reset = 1'b0;
        step(16'h0000, 0, 2'b00, O_IDLE, "midreset_idle");

        // Entry wait expiry: fault on the 256th cycle.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "ew_grant");
        for (int k = 0; k < 255; k++) step(16'h1000, 0, 2'b01, o_we(2'b01), "ew_wait");
        step(16'h1000, 0, 2'b01, O_FAULT, "ew_fault");
        step(16'hFFFE, 0, 2'b00, O_IDLE,  "ew_clear");

        // Entry at the boundary cycle wins over the timeout.
        step(16'h0000, 0, 2'b01, o_we(2'b01), "ewb_grant");
        for (int k = 0; k < 255; k++) step(16'h1000, 0, 2'b01, o_we(2'b01), "ewb_wait");
        step(16'hA000, 0, 2'b01, o_in(2'b01), "ewb_enter");

        // Long stay inside SMEM.
`ifdef SMEM_RUN_TIMEOUT_EN
        for (int k = 0; k < 15; k++) step(16'hA004, 0, 2'b01, o_in(2'b01), "rt_run");
        step(16'hA004, 0, 2'b01, O_FAULT, "rt_fault");
        step(16'hFFFE, 0, 2'b00, O_IDLE,  "rt_clear");
`else
        for (int k = 0; k < 40; k++) step(16'hA004, 0, 2'b01, o_in(2'b01), "rt_nofault");
        step(16'hDFFE, 0, 2'b01, o_in(2'b01),   "rt_last");
        step(16'h0000, 0, 2'b01, o_done(2'b01), "rt_done");
        step(16'h0000, 0, 2'b00, O_IDLE,        "rt_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
